// File: rtl/mul_seq_pp.sv
// Sequential W x W multiplier: one (W/2)x(W/2) partial product per cycle over
// four cycles, sign handled by magnitude multiply plus a final conditional negate.
module mul_seq_pp #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             sgn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*W-1:0]   c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int H = W / 2;

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // CALC  | accumulating partial product k (0..3)
  // FIX   | applying result sign, loading c
  // DONE  | holding c until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   ua_q, ua_d;
  logic [W-1:0]   ub_q, ub_d;
  logic           neg_q, neg_d;
  logic [1:0]     k_q, k_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] c_q, c_d;
  logic           ov_q, ov_d;

  logic [W-1:0]   a_mag, b_mag;
  logic [H-1:0]   a_half, b_half;
  logic [W-1:0]   pp;
  logic [2*W-1:0] pp_ext;

  // -2^(W-1) negates to itself, which read unsigned is exactly its magnitude
  assign a_mag = (sgn && a[W-1]) ? (~a + ONE_W) : a;
  assign b_mag = (sgn && b[W-1]) ? (~b + ONE_W) : b;

  // k[0] selects the high half of ua, k[1] the high half of ub
  assign a_half = k_q[0] ? ua_q[W-1:H] : ua_q[H-1:0];
  assign b_half = k_q[1] ? ub_q[W-1:H] : ub_q[H-1:0];
  assign pp     = {{H{1'b0}}, a_half} * {{H{1'b0}}, b_half};

  always_comb begin
    pp_ext = {{W{1'b0}}, pp};
    case (k_q)
      2'd0:    pp_ext = {{W{1'b0}}, pp};
      2'd1,
      2'd2:    pp_ext = {{H{1'b0}}, pp, {H{1'b0}}};
      default: pp_ext = {pp, {W{1'b0}}};
    endcase
  end

  always_comb begin
    state_d = state_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    neg_d   = neg_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_d     = c_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ua_d    = a_mag;
          ub_d    = b_mag;
          neg_d   = sgn & (a[W-1] ^ b[W-1]);
          acc_d   = '0;
          k_d     = 2'd0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + pp_ext;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_FIX;
      end
      S_FIX: begin
        c_d     = neg_q ? (~acc_q + ONE_2W) : acc_q;
        ov_d    = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ua_q    <= '0;
      ub_q    <= '0;
      neg_q   <= 1'b0;
      k_q     <= 2'd0;
      acc_q   <= '0;
      c_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      neg_q   <= neg_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign c         = c_q;

endmodule
